// File: rtl/btn_debounce.sv
// Two-channel button debouncer (pause/start and stopwatch reset) with one-cycle press strobes.
// Define BTN_LONGPRESS_EN to add a long-press strobe per channel; otherwise the long outputs tie to 0.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned LONG_CYCLES     = 2000
) (
  input  logic clk_in,
  input  logic sys_rst_n_in,
  input  logic ps_in,
  input  logic rst_in,
  output logic ps_pulse_out,
  output logic rst_pulse_out,
  output logic ps_level_out,
  output logic rst_level_out,
  output logic ps_long_out,
  output logic rst_long_out
);

  localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES
                                                                      : LONG_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef enum logic [1:0] {StIdle, StPressChk, StPressed, StReleaseChk} state_e;

  localparam cnt_t DebMax  = cnt_t'(DEBOUNCE_CYCLES);
  localparam cnt_t CntOne  = cnt_t'(1);
  localparam cnt_t CntFull = {CntW{1'b1}};

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == CntFull) ? c : c + CntOne;
  endfunction

  logic [1:0] raw;
  logic [1:0] pulse;
  logic [1:0] level;
  logic [1:0] long_pulse;

  assign raw = {rst_in, ps_in};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [1:0] sync_q;
    logic       synced;
    state_e     state_q;
    cnt_t       cnt_q;
    logic       pulse_q;
    logic       level_q;

    assign synced = sync_q[1];

    always_ff @(posedge clk_in or negedge sys_rst_n_in) begin
      if (!sys_rst_n_in) begin
        sync_q  <= '0;
        state_q <= StIdle;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw[ch]};
        pulse_q <= 1'b0;
        case (state_q)
          StIdle: begin
            if (!synced) begin
              cnt_q <= '0;
            end else if (DebMax <= CntOne) begin
              state_q <= StPressed;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              state_q <= StPressChk;
              cnt_q   <= CntOne;
            end
          end
          StPressChk: begin
            if (!synced) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q >= DebMax - CntOne) begin
              // This sample is the DEBOUNCE_CYCLES-th consecutive high.
              state_q <= StPressed;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          StPressed: begin
            if (!synced) begin
              if (DebMax <= CntOne) begin
                state_q <= StIdle;
                level_q <= 1'b0;
                cnt_q   <= '0;
              end else begin
                state_q <= StReleaseChk;
                cnt_q   <= CntOne;
              end
            end
          end
          StReleaseChk: begin
            if (synced) begin
              state_q <= StPressed;
              cnt_q   <= '0;
            end else if (cnt_q >= DebMax - CntOne) begin
              state_q <= StIdle;
              level_q <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= sat_inc(cnt_q);
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign pulse[ch] = pulse_q;
    assign level[ch] = level_q;

`ifdef BTN_LONGPRESS_EN
    localparam cnt_t LongMax = cnt_t'(LONG_CYCLES);
    cnt_t long_q;
    logic long_pulse_q;

    // Counts synced-high samples while accepted; release-check glitches pause it, never clear it.
    always_ff @(posedge clk_in or negedge sys_rst_n_in) begin
      if (!sys_rst_n_in) begin
        long_q       <= '0;
        long_pulse_q <= 1'b0;
      end else begin
        long_pulse_q <= 1'b0;
        if (state_q == StIdle || state_q == StPressChk) begin
          long_q <= '0;
        end else if (synced && long_q < LongMax) begin
          long_q <= sat_inc(long_q);
          if (long_q == LongMax - CntOne) begin
            long_pulse_q <= 1'b1;
          end
        end
      end
    end

    assign long_pulse[ch] = long_pulse_q;
`else
    assign long_pulse[ch] = 1'b0;
`endif
  end

  assign ps_pulse_out  = pulse[0];
  assign rst_pulse_out = pulse[1];
  assign ps_level_out  = level[0];
  assign rst_level_out = level[1];
  assign ps_long_out   = long_pulse[0];
  assign rst_long_out  = long_pulse[1];

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a run-length model of the accept rule checked every cycle,
// plus hand-computed edge numbers for the directed scenarios.
module tb_btn_debounce;

  localparam int unsigned D = 10;
  localparam int unsigned L = 2000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ps    = 1'b0;
  logic rb    = 1'b0;
  logic ps_pulse, rst_pulse, ps_level, rst_level, ps_long, rst_long;

  btn_debounce #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk_in       (clk),
    .sys_rst_n_in (rst_n),
    .ps_in        (ps),
    .rst_in       (rb),
    .ps_pulse_out (ps_pulse),
    .rst_pulse_out(rst_pulse),
    .ps_level_out (ps_level),
    .rst_level_out(rst_level),
    .ps_long_out  (ps_long),
    .rst_long_out (rst_long)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_bit(string name, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model: a level is accepted once the synced input differs from it for D straight samples.
  logic m_s1[2]    = '{1'b0, 1'b0};
  logic m_s2[2]    = '{1'b0, 1'b0};
  logic m_level[2] = '{1'b0, 1'b0};
  logic m_pulse[2] = '{1'b0, 1'b0};
  logic m_long[2]  = '{1'b0, 1'b0};
  int   m_run[2]   = '{0, 0};
  int   m_lc[2]    = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    logic syn, acc, raw_v;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_level[c] = 1'b0;
        m_pulse[c] = 1'b0; m_long[c] = 1'b0; m_run[c] = 0; m_lc[c] = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        raw_v = (c == 0) ? ps : rb;
        syn = m_s2[c];
        m_s2[c] = m_s1[c];
        m_s1[c] = raw_v;
        m_pulse[c] = 1'b0;
        m_long[c] = 1'b0;
        acc = 1'b0;
        if (syn != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == D) begin
            m_level[c] = syn;
            m_pulse[c] = syn;
            m_run[c] = 0;
            acc = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (m_level[c] && syn && !acc) begin
          m_lc[c]++;
`ifdef BTN_LONGPRESS_EN
          if (m_lc[c] == L) m_long[c] = 1'b1;
`endif
        end
        if (!m_level[c]) m_lc[c] = 0;
      end
    end
  end

  int ps_pulses = 0, rst_pulses = 0, ps_longs = 0;
  int ps_last = -1, rst_last = -1, ps_long_last = -1, ps_fall = -1;
  logic ps_level_prev = 1'b0;

  always @(negedge clk) begin
    check_bit("ps_pulse",  ps_pulse,  m_pulse[0]);
    check_bit("rst_pulse", rst_pulse, m_pulse[1]);
    check_bit("ps_level",  ps_level,  m_level[0]);
    check_bit("rst_level", rst_level, m_level[1]);
    check_bit("ps_long",   ps_long,   m_long[0]);
    check_bit("rst_long",  rst_long,  m_long[1]);
    if (ps_pulse === 1'b1) begin ps_pulses++; ps_last = cyc; end
    if (rst_pulse === 1'b1) begin rst_pulses++; rst_last = cyc; end
    if (ps_long === 1'b1) begin ps_longs++; ps_long_last = cyc; end
    if (ps_level_prev === 1'b1 && ps_level === 1'b0) ps_fall = cyc;
    ps_level_prev = ps_level;
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c0, r0, b, br, bl;

    step(3);
    check_bit("reset ps_level", ps_level, 1'b0);
    check_bit("reset rst_pulse", rst_pulse, 1'b0);
    rst_n = 1'b1;
    step(3);

    // 9-cycle press is too short
    b = ps_pulses;
    ps = 1'b1; step(9); ps = 1'b0; step(20);
    check_int("short press pulses", ps_pulses - b, 0);

    // 10-cycle press: pulse at edge 12, level falls 10 synced lows later
    b = ps_pulses; c0 = cyc;
    ps = 1'b1; step(10); ps = 1'b0; step(25);
    check_int("press pulses", ps_pulses - b, 1);
    check_int("press pulse edge", ps_last - c0, 12);
    check_int("release level edge", ps_fall - c0, 22);

    // bounce 3 high / 2 low / 15 high on rst
    br = rst_pulses; c0 = cyc;
    rb = 1'b1; step(3); rb = 1'b0; step(2); rb = 1'b1; step(15); rb = 1'b0; step(25);
    check_int("bounce pulses", rst_pulses - br, 1);
    check_int("bounce pulse edge", rst_last - c0, 17);

    // release glitch shorter than D must not re-pulse
    b = ps_pulses;
    ps = 1'b1; step(15); ps = 1'b0; step(3); ps = 1'b1; step(15); ps = 1'b0; step(25);
    check_int("glitch pulses", ps_pulses - b, 1);

    // reset mid-count discards progress
    b = ps_pulses; c0 = cyc;
    ps = 1'b1; step(7);
    rst_n = 1'b0; step(1);
    check_int("no pulse before reset", ps_pulses - b, 0);
    rst_n = 1'b1; r0 = cyc;
    step(20); ps = 1'b0; step(25);
    check_int("post-reset pulses", ps_pulses - b, 1);
    check_int("post-reset pulse edge", ps_last - r0, 12);

    // simultaneous presses
    b = ps_pulses; br = rst_pulses; c0 = cyc;
    ps = 1'b1; rb = 1'b1; step(20); ps = 1'b0; rb = 1'b0; step(25);
    check_int("dual ps pulses", ps_pulses - b, 1);
    check_int("dual rst pulses", rst_pulses - br, 1);
    check_int("dual ps edge", ps_last - c0, 12);
    check_int("dual rst edge", rst_last - c0, 12);

    // asynchronous reset clears an accepted level immediately
    ps = 1'b1; step(15);
    check_bit("held level", ps_level, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_bit("async reset level", ps_level, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; ps = 1'b0; step(25);

    // long hold
    b = ps_pulses; bl = ps_longs; c0 = cyc;
    ps = 1'b1; step(2015); ps = 1'b0; step(25);
    check_int("long hold pulses", ps_pulses - b, 1);
`ifdef BTN_LONGPRESS_EN
    check_int("long strobes", ps_longs - bl, 1);
    check_int("long strobe edge", ps_long_last - c0, 2012);
`else
    check_int("long strobes", ps_longs - bl, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 10; consecutive stable clk_in cycles needed to accept a level change (10 ms at 1 kHz).
REQ-002 SHALL have parameter LONG_CYCLES, default 2000; held-press cycles for a long-press event (used only with BTN_LONGPRESS_EN).
REQ-003 SHALL have port clk_in, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_n_in, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port ps_in, input, 1, raw pause/start button, active-high, asynchronous and bouncy.
REQ-006 SHALL have port rst_in, input, 1, raw stopwatch-reset button, active-high, asynchronous and bouncy.
REQ-007 SHALL have port ps_pulse_out, output, 1, one-cycle strobe per accepted ps press.
REQ-008 SHALL have port rst_pulse_out, output, 1, one-cycle strobe per accepted rst press.
REQ-009 SHALL have port ps_level_out, output, 1, debounced ps level.
REQ-010 SHALL have port rst_level_out, output, 1, debounced rst level.
REQ-011 SHALL have ports ps_long_out and rst_long_out, output, 1 each, one-cycle long-press strobes.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; only the synchronized value feeds the FSM.
REQ-013 Each channel SHALL have an independent FSM with states IDLE, PRESS_CHK, PRESSED, RELEASE_CHK.
REQ-014 IDLE: synced=1 -> PRESS_CHK with count=1; else stay.
REQ-015 PRESS_CHK: synced=0 -> IDLE with count cleared, no output; synced=1 -> count+1; when count reaches DEBOUNCE_CYCLES -> PRESSED.
REQ-016 Entry into PRESSED SHALL assert pulse_out for exactly one cycle and set level_out=1 on the same edge.
REQ-017 Latency: pulse_out SHALL first be high at rising edge DEBOUNCE_CYCLES+2 counted from the first edge that samples raw input high, with input held high throughout.
REQ-018 PRESSED: synced=0 -> RELEASE_CHK with count=1.
REQ-019 RELEASE_CHK: synced=1 -> PRESSED with no new pulse; DEBOUNCE_CYCLES consecutive lows -> IDLE with level_out=0.
REQ-020 A press shorter than DEBOUNCE_CYCLES synced cycles, including bounce gaps, SHALL produce no output.
REQ-021 The counter SHALL be $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1) bits wide and SHALL saturate, never wrap.
REQ-022 Channels SHALL be independent: simultaneous accepted presses SHALL assert both pulses in the same cycle.
REQ-023 A held button SHALL produce exactly one pulse_out until released and re-accepted.

Reset
REQ-024 sys_rst_n_in low SHALL immediately force FSMs to IDLE, clear counters and synchronizers, and drive all outputs 0.
REQ-025 Reset asserted mid-count SHALL discard partial counts; after release a full DEBOUNCE_CYCLES of stable high is required.
REQ-026 A button already held high at reset release SHALL be accepted as a new press after REQ-017 latency.

Configuration
REQ-027 Macro BTN_LONGPRESS_EN defined: in PRESSED, after LONG_CYCLES further consecutive synced-high cycles, long_out SHALL pulse once per hold; a RELEASE_CHK glitch returning to PRESSED SHALL not restart the long count.
REQ-028 Macro BTN_LONGPRESS_EN undefined: ps_long_out and rst_long_out SHALL be constant 0 and no long-press counter logic SHALL be synthesized; ports remain present.

Verification
REQ-029 ps_in high 9 cycles then low -> ps_pulse_out and ps_level_out stay 0.
REQ-030 ps_in high 10 cycles -> one ps_pulse_out at edge 12; ps_level_out 1, then 0 ten synced-low cycles after release.
REQ-031 rst_in bounce 3 high / 2 low / 15 high -> exactly one rst_pulse_out; count restarts after the gap.
REQ-032 ps_in high, sys_rst_n_in low at count 5 for 1 cycle, ps_in kept high -> outputs 0 during reset; pulse at edge 12 after reset release.
REQ-033 ps_in and rst_in rise on the same edge, held 20 cycles -> ps_pulse_out and rst_pulse_out high in the same single cycle.
REQ-034 ps_in held 2015 cycles with BTN_LONGPRESS_EN -> one ps_pulse_out, then one ps_long_out 2000 cycles later; without the macro ps_long_out stays 0.
